// File: rtl/ld_st_control_unit_pkg.sv
// Shared types and constants for the ld/st hardwired control unit: state
// encodings, opcodes, ALU codes and MDR source selects.
package cpu_ctrl_pkg;

   typedef enum logic [4:0] {
      IDLE = 5'd0,
      T0   = 5'd1,
      T1   = 5'd2,
      T2   = 5'd3,
      T3   = 5'd4,
      T4   = 5'd5,
      T5   = 5'd6,
      T6   = 5'd7,
      T7   = 5'd8,
      HALT = 5'd9
   } state_t;

   localparam logic [4:0] OPC_LD   = 5'b00000;
   localparam logic [4:0] OPC_LDI  = 5'b00001;
   localparam logic [4:0] OPC_ST   = 5'b00010;
   localparam logic [4:0] OPC_NOP  = 5'b11010;
   localparam logic [4:0] OPC_HALT = 5'b11011;

   localparam logic [3:0] ALU_OP_NONE = 4'd0;
   localparam logic [3:0] ALU_OP_ADD  = 4'd2;

   localparam logic [1:0] MDR_SRC_BUS = 2'b00;
   localparam logic [1:0] MDR_SRC_MEM = 2'b01;

   typedef enum logic [2:0] {
      OP_LD      = 3'd0,
      OP_LDI     = 3'd1,
      OP_ST      = 3'd2,
      OP_NOP     = 3'd3,
      OP_HALT    = 3'd4,
      OP_ILLEGAL = 3'd5
   } op_class_t;

   function automatic op_class_t decode_op(input logic [4:0] opcode);
      op_class_t cls;
      case (opcode)
         OPC_LD:   cls = OP_LD;
         OPC_LDI:  cls = OP_LDI;
         OPC_ST:   cls = OP_ST;
         OPC_NOP:  cls = OP_NOP;
         OPC_HALT: cls = OP_HALT;
         default:  cls = OP_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/ld_st_control_unit_if.sv
// Handshake/strobe bundle between the control unit (master) and the
// datapath/memory side (slave). mem_err exists only with CU_WAIT_TIMEOUT_EN.
interface ld_st_control_unit_if;

   logic       start;
   logic       mem_ready;
   logic [4:0] ir_opcode;

   logic       PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPc, Zlowin, Cout;
   logic       read, write;
   logic       GRA, GRB, GRC, Rin, Rout, BAout;
   logic [1:0] mdr_read;
   logic [3:0] control;
   logic       busy;
   logic       halted;
   logic       illegal_op;
   logic [4:0] state_dbg;
`ifdef CU_WAIT_TIMEOUT_EN
   logic       mem_err;
`endif

   modport master (
      input  start, mem_ready, ir_opcode,
      output PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPc, Zlowin, Cout,
      output read, write, GRA, GRB, GRC, Rin, Rout, BAout,
      output mdr_read, control, busy, halted, illegal_op, state_dbg
`ifdef CU_WAIT_TIMEOUT_EN
      , output mem_err
`endif
   );

   modport slave (
      output start, mem_ready, ir_opcode,
      input  PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPc, Zlowin, Cout,
      input  read, write, GRA, GRB, GRC, Rin, Rout, BAout,
      input  mdr_read, control, busy, halted, illegal_op, state_dbg
`ifdef CU_WAIT_TIMEOUT_EN
      , input mem_err
`endif
   );

endinterface

// File: rtl/cu_wait_timer.sv
// Wait-state watchdog: counts cycles with mem_ready low inside a wait state
// and flags the cycle on which the count reaches TIMEOUT_CYCLES.
module cu_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic wait_active,
   input  logic wait_first,
   input  logic mem_ready,
   output logic timeout
);

   localparam logic [3:0] LIMIT = 4'(TIMEOUT_CYCLES);

   logic [3:0] cnt_r;
   logic [3:0] cnt_nxt_s;
   logic [3:0] base_s;
   logic [3:0] inc_s;

   // Count restarts from zero on the first cycle of every wait state.
   always_comb begin
      cnt_nxt_s = 4'd0;
      timeout   = 1'b0;
      base_s    = wait_first ? 4'd0 : cnt_r;
      inc_s     = base_s + 4'd1;
      if (wait_active && !mem_ready) begin
         cnt_nxt_s = inc_s;
         timeout   = (inc_s == LIMIT);
      end else if (wait_active) begin
         cnt_nxt_s = base_s;
      end else begin
         cnt_nxt_s = 4'd0;
      end
   end

   // Wait counter register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_r <= 4'd0;
      end else begin
         cnt_r <= cnt_nxt_s;
      end
   end

endmodule

// File: rtl/ld_st_control_unit.sv
// Hardwired Moore control unit sequencing fetch and ld/ldi/st/nop/halt on the
// bus datapath. Optional wait-state timeout: define CU_WAIT_TIMEOUT_EN.
module ld_st_control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter logic [3:0] ALU_ADD = ALU_OP_ADD
`ifdef CU_WAIT_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 15
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   ld_st_control_unit_if.master  bus
);

   state_t    state_r;
   state_t    state_nxt_s;
   op_class_t op_r;
   op_class_t op_nxt_s;
   op_class_t dec_s;
   logic      first_r;
   logic      illegal_op_r;
   logic      illegal_set_s;
   logic      timeout_s;

   assign dec_s = decode_op(bus.ir_opcode);

`ifdef CU_WAIT_TIMEOUT_EN
   logic wait_active_s;
   logic mem_err_r;

   assign wait_active_s = (state_r == T1) ||
                          ((state_r == T6) && (op_r == OP_LD)) ||
                          ((state_r == T7) && (op_r == OP_ST));

   cu_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk         (clk),
      .reset       (reset),
      .wait_active (wait_active_s),
      .wait_first  (first_r),
      .mem_ready   (bus.mem_ready),
      .timeout     (timeout_s)
   );

   // Sticky memory error, set when a wait state runs out of patience.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_err_r <= 1'b0;
      end else if (timeout_s) begin
         mem_err_r <= 1'b1;
      end else begin
         mem_err_r <= mem_err_r;
      end
   end

   assign bus.mem_err = mem_err_r;
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state logic; the op class is captured at decode so T5..T7 no longer
   // depend on the IR contents.
   always_comb begin
      state_nxt_s   = state_r;
      op_nxt_s      = op_r;
      illegal_set_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) state_nxt_s = T0;
            else           state_nxt_s = IDLE;
         end
         T0: state_nxt_s = T1;
         T1: begin
            if (bus.mem_ready)   state_nxt_s = T2;
            else if (timeout_s)  state_nxt_s = HALT;
            else                 state_nxt_s = T1;
         end
         T2: state_nxt_s = T3;
         T3: begin
            case (dec_s)
               OP_LD, OP_LDI, OP_ST: begin
                  state_nxt_s = T4;
                  op_nxt_s    = dec_s;
               end
               OP_NOP:  state_nxt_s = T0;
               OP_HALT: state_nxt_s = HALT;
               default: begin
                  state_nxt_s   = HALT;
                  illegal_set_s = 1'b1;
               end
            endcase
         end
         T4: state_nxt_s = T5;
         T5: begin
            if (op_r == OP_LDI) state_nxt_s = T0;
            else                state_nxt_s = T6;
         end
         T6: begin
            if (op_r == OP_ST)       state_nxt_s = T7;
            else if (bus.mem_ready)  state_nxt_s = T7;
            else if (timeout_s)      state_nxt_s = HALT;
            else                     state_nxt_s = T6;
         end
         T7: begin
            if (op_r == OP_LD)       state_nxt_s = T0;
            else if (bus.mem_ready)  state_nxt_s = T0;
            else if (timeout_s)      state_nxt_s = HALT;
            else                     state_nxt_s = T7;
         end
         HALT:    state_nxt_s = HALT;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, op class, first-cycle flag and sticky illegal flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r      <= IDLE;
         op_r         <= OP_NOP;
         first_r      <= 1'b1;
         illegal_op_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         op_r         <= op_nxt_s;
         first_r      <= (state_nxt_s != state_r);
         illegal_op_r <= illegal_op_r | illegal_set_s;
      end
   end

   // Moore output decode; every strobe defaults low.
   always_comb begin
      bus.PCout    = 1'b0;
      bus.Zlowout  = 1'b0;
      bus.MDRout   = 1'b0;
      bus.MARin    = 1'b0;
      bus.PCin     = 1'b0;
      bus.MDRin    = 1'b0;
      bus.IRin     = 1'b0;
      bus.Yin      = 1'b0;
      bus.IncPc    = 1'b0;
      bus.Zlowin   = 1'b0;
      bus.Cout     = 1'b0;
      bus.read     = 1'b0;
      bus.write    = 1'b0;
      bus.GRA      = 1'b0;
      bus.GRB      = 1'b0;
      bus.GRC      = 1'b0;
      bus.Rin      = 1'b0;
      bus.Rout     = 1'b0;
      bus.BAout    = 1'b0;
      bus.mdr_read = MDR_SRC_BUS;
      bus.control  = ALU_OP_NONE;
      case (state_r)
         T0: begin
            bus.PCout  = 1'b1;
            bus.MARin  = 1'b1;
            bus.IncPc  = 1'b1;
            bus.Zlowin = 1'b1;
         end
         T1: begin
            bus.Zlowout  = 1'b1;
            bus.PCin     = first_r;
            bus.read     = 1'b1;
            bus.MDRin    = 1'b1;
            bus.mdr_read = MDR_SRC_MEM;
         end
         T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
         end
         T3: begin
            if ((dec_s == OP_LD) || (dec_s == OP_LDI) || (dec_s == OP_ST)) begin
               bus.GRB   = 1'b1;
               bus.BAout = 1'b1;
               bus.Yin   = 1'b1;
            end else begin
               bus.GRB   = 1'b0;
            end
         end
         T4: begin
            bus.Cout    = 1'b1;
            bus.Zlowin  = 1'b1;
            bus.control = ALU_ADD;
         end
         T5: begin
            bus.Zlowout = 1'b1;
            if (op_r == OP_LDI) begin
               bus.GRA = 1'b1;
               bus.Rin = 1'b1;
            end else begin
               bus.MARin = 1'b1;
            end
         end
         T6: begin
            bus.MDRin = 1'b1;
            if (op_r == OP_ST) begin
               bus.GRA  = 1'b1;
               bus.Rout = 1'b1;
            end else begin
               bus.read     = 1'b1;
               bus.mdr_read = MDR_SRC_MEM;
            end
         end
         T7: begin
            bus.MDRout = 1'b1;
            if (op_r == OP_ST) begin
               bus.write = 1'b1;
            end else begin
               bus.GRA = 1'b1;
               bus.Rin = 1'b1;
            end
         end
         default: begin
            bus.PCout = 1'b0;
         end
      endcase
   end

   assign bus.busy       = (state_r != IDLE) && (state_r != HALT);
   assign bus.halted     = (state_r == HALT);
   assign bus.illegal_op = illegal_op_r;
   assign bus.state_dbg  = state_r;

endmodule

// File: tb/tb_ld_st_control_unit.sv
// Directed, table-driven bench for ld_st_control_unit plus hand-written
// multi-cycle sequences (ld with T6 wait states, optional wait timeout).
module tb_ld_st_control_unit;

   localparam logic [4:0] SI = 5'd0, S0 = 5'd1, S1 = 5'd2, S2 = 5'd3, S3 = 5'd4;
   localparam logic [4:0] S4 = 5'd5, S5 = 5'd6, S6 = 5'd7, S7 = 5'd8, SH = 5'd9;
   localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010;
   localparam logic [4:0] NOP = 5'b11010, HLT = 5'b11011, BAD = 5'b10101;

   // strobe vector order: PCout Zlowout MDRout MARin PCin MDRin IRin Yin IncPc
   // Zlowin Cout read write GRA GRB GRC Rin Rout BAout
   localparam logic [18:0] PCOUT = 19'h40000, ZLOWOUT = 19'h20000, MDROUT = 19'h10000;
   localparam logic [18:0] MARIN = 19'h08000, PCIN = 19'h04000, MDRIN = 19'h02000;
   localparam logic [18:0] IRIN = 19'h01000, YIN = 19'h00800, INCPC = 19'h00400;
   localparam logic [18:0] ZLOWIN = 19'h00200, COUT = 19'h00100, READ = 19'h00080;
   localparam logic [18:0] WRITE = 19'h00040, GRA = 19'h00020, GRB = 19'h00010;
   localparam logic [18:0] GRC = 19'h00008, RIN = 19'h00004, ROUT = 19'h00002;
   localparam logic [18:0] BAOUT = 19'h00001, NONE = 19'h00000;

   localparam logic [18:0] M_T0  = PCOUT | MARIN | INCPC | ZLOWIN;
   localparam logic [18:0] M_T1F = ZLOWOUT | PCIN | READ | MDRIN;
   localparam logic [18:0] M_T1W = ZLOWOUT | READ | MDRIN;
   localparam logic [18:0] M_T2  = MDROUT | IRIN;
   localparam logic [18:0] M_T3  = GRB | BAOUT | YIN;
   localparam logic [18:0] M_T4  = COUT | ZLOWIN;
   localparam logic [18:0] M_T5I = ZLOWOUT | GRA | RIN;
   localparam logic [18:0] M_T5M = ZLOWOUT | MARIN;
   localparam logic [18:0] M_T6L = READ | MDRIN;
   localparam logic [18:0] M_T6S = GRA | ROUT | MDRIN;
   localparam logic [18:0] M_T7L = MDROUT | GRA | RIN;
   localparam logic [18:0] M_T7S = WRITE | MDROUT;

   typedef struct {
      string       name;
      logic        rst;
      logic        start;
      logic        mrdy;
      logic [4:0]  op;
      logic [4:0]  st;
      logic [18:0] strb;
      logic [1:0]  mdr;
      logic [3:0]  ctl;
      logic        busy;
      logic        halted;
      logic        ill;
   } vec_t;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   vec_t tbl[$];

   ld_st_control_unit_if bus ();

   ld_st_control_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input string n, input logic r, input logic s, input logic m,
                      input logic [4:0] op, input logic [4:0] st, input logic [18:0] strb,
                      input logic [1:0] mdr, input logic [3:0] ctl, input logic ill);
      vec_t v;
      v.name = n; v.rst = r; v.start = s; v.mrdy = m; v.op = op; v.st = st;
      v.strb = strb; v.mdr = mdr; v.ctl = ctl; v.ill = ill;
      v.busy   = (st != SI) && (st != SH);
      v.halted = (st == SH);
      tbl.push_back(v);
   endtask

   task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, got, exp);
      end
   endtask

   function automatic logic [27:0] outs();
      return {bus.PCout, bus.Zlowout, bus.MDRout, bus.MARin, bus.PCin, bus.MDRin,
              bus.IRin, bus.Yin, bus.IncPc, bus.Zlowin, bus.Cout, bus.read, bus.write,
              bus.GRA, bus.GRB, bus.GRC, bus.Rin, bus.Rout, bus.BAout,
              bus.mdr_read, bus.control, bus.busy, bus.halted, bus.illegal_op};
   endfunction

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b0;
      bus.start = 1'b0;
      bus.mem_ready = 1'b0;
      bus.ir_opcode = 5'd0;

      // reset and idle
      add("rst0", 1'b0, 1'b0, 1'b0, LD, SI, NONE, 2'b00, 4'd0, 1'b0);
      add("rst1", 1'b0, 1'b0, 1'b0, LD, SI, NONE, 2'b00, 4'd0, 1'b0);
      for (int i = 0; i < 5; i++)
         add("idle", 1'b1, 1'b0, 1'b0, LD, SI, NONE, 2'b00, 4'd0, 1'b0);
      // ld, zero-wait memory
      add("ld_t0", 1'b1, 1'b1, 1'b1, LD, S0, M_T0,  2'b00, 4'd0, 1'b0);
      add("ld_t1", 1'b1, 1'b0, 1'b1, LD, S1, M_T1F, 2'b01, 4'd0, 1'b0);
      add("ld_t2", 1'b1, 1'b0, 1'b1, LD, S2, M_T2,  2'b00, 4'd0, 1'b0);
      add("ld_t3", 1'b1, 1'b0, 1'b1, LD, S3, M_T3,  2'b00, 4'd0, 1'b0);
      add("ld_t4", 1'b1, 1'b0, 1'b1, LD, S4, M_T4,  2'b00, 4'd2, 1'b0);
      add("ld_t5", 1'b1, 1'b0, 1'b1, LD, S5, M_T5M, 2'b00, 4'd0, 1'b0);
      add("ld_t6", 1'b1, 1'b0, 1'b1, LD, S6, M_T6L, 2'b01, 4'd0, 1'b0);
      add("ld_t7", 1'b1, 1'b0, 1'b1, LD, S7, M_T7L, 2'b00, 4'd0, 1'b0);
      add("ld_end", 1'b1, 1'b0, 1'b1, LD, S0, M_T0, 2'b00, 4'd0, 1'b0);
      // st, three wait cycles in T7; mem_ready low in st T6 is ignored
      add("st_t1", 1'b1, 1'b0, 1'b1, ST, S1, M_T1F, 2'b01, 4'd0, 1'b0);
      add("st_t2", 1'b1, 1'b0, 1'b1, ST, S2, M_T2,  2'b00, 4'd0, 1'b0);
      add("st_t3", 1'b1, 1'b0, 1'b1, ST, S3, M_T3,  2'b00, 4'd0, 1'b0);
      add("st_t4", 1'b1, 1'b0, 1'b1, ST, S4, M_T4,  2'b00, 4'd2, 1'b0);
      add("st_t5", 1'b1, 1'b0, 1'b1, ST, S5, M_T5M, 2'b00, 4'd0, 1'b0);
      add("st_t6", 1'b1, 1'b0, 1'b1, ST, S6, M_T6S, 2'b00, 4'd0, 1'b0);
      add("st_t7", 1'b1, 1'b0, 1'b0, ST, S7, M_T7S, 2'b00, 4'd0, 1'b0);
      for (int i = 0; i < 3; i++)
         add("st_wait", 1'b1, 1'b0, 1'b0, ST, S7, M_T7S, 2'b00, 4'd0, 1'b0);
      add("st_end", 1'b1, 1'b0, 1'b1, ST, S0, M_T0, 2'b00, 4'd0, 1'b0);
      // ldi with one T1 wait cycle
      add("ldi_t1", 1'b1, 1'b0, 1'b0, LDI, S1, M_T1F, 2'b01, 4'd0, 1'b0);
      add("ldi_t1w", 1'b1, 1'b0, 1'b0, LDI, S1, M_T1W, 2'b01, 4'd0, 1'b0);
      add("ldi_t2", 1'b1, 1'b0, 1'b1, LDI, S2, M_T2,  2'b00, 4'd0, 1'b0);
      add("ldi_t3", 1'b1, 1'b0, 1'b1, LDI, S3, M_T3,  2'b00, 4'd0, 1'b0);
      add("ldi_t4", 1'b1, 1'b0, 1'b1, LDI, S4, M_T4,  2'b00, 4'd2, 1'b0);
      add("ldi_t5", 1'b1, 1'b0, 1'b1, LDI, S5, M_T5I, 2'b00, 4'd0, 1'b0);
      add("ldi_end", 1'b1, 1'b0, 1'b1, LDI, S0, M_T0, 2'b00, 4'd0, 1'b0);
      // nop
      add("nop_t1", 1'b1, 1'b0, 1'b1, NOP, S1, M_T1F, 2'b01, 4'd0, 1'b0);
      add("nop_t2", 1'b1, 1'b0, 1'b1, NOP, S2, M_T2,  2'b00, 4'd0, 1'b0);
      add("nop_t3", 1'b1, 1'b0, 1'b1, NOP, S3, NONE,  2'b00, 4'd0, 1'b0);
      add("nop_end", 1'b1, 1'b0, 1'b1, NOP, S0, M_T0, 2'b00, 4'd0, 1'b0);
      // halt, then start held high for 20 cycles
      add("hlt_t1", 1'b1, 1'b0, 1'b1, HLT, S1, M_T1F, 2'b01, 4'd0, 1'b0);
      add("hlt_t2", 1'b1, 1'b0, 1'b1, HLT, S2, M_T2,  2'b00, 4'd0, 1'b0);
      add("hlt_t3", 1'b1, 1'b0, 1'b1, HLT, S3, NONE,  2'b00, 4'd0, 1'b0);
      add("hlt",    1'b1, 1'b0, 1'b1, HLT, SH, NONE,  2'b00, 4'd0, 1'b0);
      for (int i = 0; i < 20; i++)
         add("hlt_hold", 1'b1, 1'b1, 1'b1, HLT, SH, NONE, 2'b00, 4'd0, 1'b0);
      add("hlt_rst", 1'b0, 1'b0, 1'b1, HLT, SI, NONE, 2'b00, 4'd0, 1'b0);
      // illegal opcode
      add("ill_t0", 1'b1, 1'b1, 1'b1, BAD, S0, M_T0,  2'b00, 4'd0, 1'b0);
      add("ill_t1", 1'b1, 1'b0, 1'b1, BAD, S1, M_T1F, 2'b01, 4'd0, 1'b0);
      add("ill_t2", 1'b1, 1'b0, 1'b1, BAD, S2, M_T2,  2'b00, 4'd0, 1'b0);
      add("ill_t3", 1'b1, 1'b0, 1'b1, BAD, S3, NONE,  2'b00, 4'd0, 1'b0);
      add("ill_hlt", 1'b1, 1'b0, 1'b1, BAD, SH, NONE, 2'b00, 4'd0, 1'b1);
      add("ill_hold", 1'b1, 1'b1, 1'b1, BAD, SH, NONE, 2'b00, 4'd0, 1'b1);
      add("ill_rst", 1'b0, 1'b0, 1'b1, BAD, SI, NONE, 2'b00, 4'd0, 1'b0);
      // reset while waiting in T1
      add("rw_t0", 1'b1, 1'b1, 1'b0, LD, S0, M_T0,  2'b00, 4'd0, 1'b0);
      add("rw_t1", 1'b1, 1'b0, 1'b0, LD, S1, M_T1F, 2'b01, 4'd0, 1'b0);
      add("rw_t1w", 1'b1, 1'b0, 1'b0, LD, S1, M_T1W, 2'b01, 4'd0, 1'b0);
      add("rw_rst", 1'b0, 1'b0, 1'b0, LD, SI, NONE, 2'b00, 4'd0, 1'b0);
      add("rw_idle", 1'b1, 1'b0, 1'b0, LD, SI, NONE, 2'b00, 4'd0, 1'b0);

      foreach (tbl[i]) begin
         reset         = tbl[i].rst;
         bus.start     = tbl[i].start;
         bus.mem_ready = tbl[i].mrdy;
         bus.ir_opcode = tbl[i].op;
         step();
         check({tbl[i].name, "_state"}, 32'(bus.state_dbg), 32'(tbl[i].st));
         check({tbl[i].name, "_outs"}, 32'(outs()),
               32'({tbl[i].strb, tbl[i].mdr, tbl[i].ctl, tbl[i].busy, tbl[i].halted, tbl[i].ill}));
      end

      // ld with two wait cycles in T6: latency T0 -> T0 and read hold length
      begin
         int cycles;
         int t6_reads;
         int waits;
         bus.ir_opcode = LD;
         bus.mem_ready = 1'b1;
         bus.start     = 1'b1;
         step();
         bus.start = 1'b0;
         cycles = 0;
         t6_reads = 0;
         waits = 0;
         while (cycles < 40) begin
            if (bus.state_dbg == S6 && bus.read) t6_reads++;
            if (bus.state_dbg == S6 && waits < 2) begin
               bus.mem_ready = 1'b0;
               waits++;
            end else begin
               bus.mem_ready = 1'b1;
            end
            step();
            cycles++;
            if (bus.state_dbg == S0) break;
         end
         check("ldw_latency", 32'(cycles), 32'd10);
         check("ldw_t6_reads", 32'(t6_reads), 32'd3);
      end

`ifdef CU_WAIT_TIMEOUT_EN
      // mem_ready stuck low in T1 must end in HALT with mem_err
      begin
         int t1_cycles;
         int n;
         reset = 1'b0;
         step();
         reset = 1'b1;
         bus.mem_ready = 1'b0;
         bus.start = 1'b1;
         step();
         bus.start = 1'b0;
         t1_cycles = 0;
         n = 0;
         while (n < 40 && bus.state_dbg != SH) begin
            step();
            if (bus.state_dbg == S1) t1_cycles++;
            n++;
         end
         check("to_state", 32'(bus.state_dbg), 32'(SH));
         check("to_t1_cycles", 32'(t1_cycles), 32'd15);
         check("to_mem_err", 32'(bus.mem_err), 32'd1);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ld_st_control_unit.md
Name: ld_st_control_unit

Overview:
- Hardwired Moore control unit that sequences the 32-bit bus datapath through instruction fetch and execution of ld, ldi, st, nop and halt.
- Drives the same strobe set that datapath bench sequences drive by hand today, including select-and-encode (GRA/GRB/GRC, Rin/Rout/BAout).
- Sits between the memory subsystem and the datapath; holds memory strobes until `mem_ready`.

Parameters:
- TIMEOUT_CYCLES, 15, maximum wait-state cycles before a memory error. Used only with CU_WAIT_TIMEOUT_EN.
- ALU_ADD, 4'd2, ALU `control` code for add.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  leave IDLE and begin fetching
- mem_ready  in  1  memory completed current read/write
- ir_opcode  in  5  IR[31:27] from the datapath
- PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPc, Zlowin, Cout  out  1 each  datapath strobes
- read, write  out  1 each  memory strobes
- GRA, GRB, GRC, Rin, Rout, BAout  out  1 each  register select/encode
- mdr_read  out  2  MDR source: 00 = bus, 01 = memory
- control  out  4  ALU op
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- illegal_op  out  1  sticky; set on an unknown opcode
- state_dbg  out  5  current state encoding

Behaviour:
- State register updates on posedge clk.
- All outputs are decoded combinationally from the state (pure Moore). Any strobe not listed for a state is 0; `control` = 0 and `mdr_read` = 00 unless listed.
- reset low at a clock edge:
  - state goes to IDLE and illegal_op clears.
  - Every strobe is 0, busy = 0, halted = 0.
  - This overrides everything, including a pending wait state: a memory transaction in flight is abandoned.
- IDLE: start = 1 → T0.
- Fetch:
  - T0: PCout, MARin, IncPc, Zlowin.
  - T1: Zlowout, PCin, read, MDRin, mdr_read = 01. Stays in T1 until mem_ready = 1, then → T2. PCin in T1 is a 1-cycle pulse: the first T1 cycle only, tracked by a first-cycle flag.
  - T2: MDRout, IRin → T3.
- T3 decode uses the ir_opcode latched by IRin:
  - 00000 ld, 00001 ldi, 00010 st, 11010 nop, 11011 halt.
  - ld / ldi / st: assert GRB, BAout, Yin → T4.
  - nop: no strobes → T0.
  - halt → HALT.
  - Any other opcode: set illegal_op → HALT.
- T4 (ld/ldi/st): Cout, Zlowin, control = ALU_ADD.
- T5:
  - ldi: Zlowout, GRA, Rin → T0.
  - ld/st: Zlowout, MARin → T6.
- T6:
  - ld: read, MDRin, mdr_read = 01. Wait for mem_ready, then → T7.
  - st: GRA, Rout, MDRin, mdr_read = 00 → T7.
- T7:
  - ld: MDRout, GRA, Rin → T0.
  - st: write, MDRout. Wait for mem_ready, then → T0.
- mem_ready:
  - Sampled only in the wait states (T1, ld T6, st T7); ignored elsewhere.
  - If high on the first cycle of a wait state, zero wait cycles are added.
- Latency with zero-wait memory:
  - ld = 8 cycles, st = 8, ldi = 6, nop = 4 (T0–T3).
- HALT: halted = 1 and all strobes 0; leaves HALT only through reset.
- start is ignored outside IDLE.

Optional Feature:
- CU_WAIT_TIMEOUT_EN defined:
  - A 4-bit wait counter clears on entry to each wait state and increments each cycle mem_ready = 0.
  - When the count reaches TIMEOUT_CYCLES → HALT, and sticky output `mem_err` (1 bit) is set. reset clears it.
- Undefined: waits are unbounded; no mem_err port and no counter.

Decomposition:
- Package `cpu_ctrl_pkg` holds:
  - state enumeration (5-bit localparams: IDLE, T0–T7, HALT)
  - opcode constants
  - ALU op codes
  - mdr_read encodings
- Sub-module `cu_wait_timer` (counter + compare) is instantiated only under CU_WAIT_TIMEOUT_EN.
- The state register and output decode stay in the top module.

Test Plan:
- Reset/IDLE: hold reset = 0 for 2 cycles, then release with start = 0 → all strobes 0, busy = 0, state_dbg = IDLE for 5 cycles.
- ld zero-wait:
  - Stimulus: start pulse, mem_ready = 1, ir_opcode = 00000.
  - Response: 8-cycle T0..T7 sequence; control = 2 only in T4; Rin only in T7; returns to T0.
- st with wait:
  - Stimulus: ir_opcode = 00010, mem_ready low for 3 cycles in T7.
  - Response: write held 4 cycles; Rout only in T6; then T0.
- ldi / nop / halt:
  - ldi: Rin in T5, next state T0.
  - nop: T3 → T0.
  - halt (11011): halted = 1 and stays there for 20 cycles despite start = 1.
- Illegal opcode 10101 → illegal_op = 1, HALT. Then a reset pulse → illegal_op = 0, IDLE.
- Reset in T1 wait with read = 1 → next cycle read = 0 and IDLE.
- With CU_WAIT_TIMEOUT_EN: mem_ready held 0 in T1 → HALT and mem_err = 1 after 15 wait cycles.
